// File: rtl/spi_target_regfile.sv
// SPI target with a byte-wide register file; all state lives in the SCLK domain.
// Frames are a command byte (bit7 = read, bits 6:0 = start address) then data bytes with auto-increment.
module spi_target_regfile #(
  parameter int         NREGS     = 8,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                     spi_clock,
  input  logic                     sysrst_n,
  input  logic                     cs_n,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  output logic [8*NREGS-1:0]       reg_q,
  input  logic                     local_we,
  input  logic [$clog2(NREGS)-1:0] local_addr,
  input  logic [7:0]               local_din,
  output logic [7:0]               rx_byte,
  output logic                     rx_valid,
  output logic                     frame_err,
  input  logic                     err_clr,
  output logic                     active
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t         state;
  state_t         state_next;
  logic [7:0]     rx_sr;
  logic [7:0]     tx_sr;
  logic [2:0]     bit_cnt;
  logic [AW-1:0]  addr;
  logic           oor;
  logic [7:0]     regs [NREGS];

  logic           byte_done;
  logic [7:0]     rx_next;
  logic [AW-1:0]  cmd_addr;
  logic           cmd_oor;
  logic           cmd_done;
  logic           spi_we;
  logic           load_tx;
  logic           addr_step;
  logic [AW-1:0]  rd_addr;
  logic           rd_oor;
  logic [7:0]     rd_byte;

  assign byte_done = !cs_n && (bit_cnt == 3'd7);
  assign rx_next   = {rx_sr[6:0], mosi};
  assign cmd_addr  = rx_next[AW-1:0];
  // Any address bit at or above AW marks the whole frame out-of-range.
  assign cmd_oor   = (rx_next[6:0] >> AW) != 7'd0;

  // FSM: state register
  always_ff @(posedge spi_clock or negedge sysrst_n) begin
    if (!sysrst_n) state <= IDLE;
    else           state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    if (cs_n) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = CMD;
        CMD:     if (byte_done) state_next = rx_next[7] ? RDATA : WDATA;
        default: state_next = state;
      endcase
    end
  end

  // FSM: output strobes, all qualified by a completed byte
  always_comb begin
    cmd_done  = 1'b0;
    spi_we    = 1'b0;
    load_tx   = 1'b0;
    addr_step = 1'b0;
    if (byte_done) begin
      case (state)
        CMD: begin
          cmd_done = 1'b1;
          load_tx  = rx_next[7];
        end
        WDATA: begin
          spi_we    = !oor;
          addr_step = 1'b1;
        end
        RDATA: begin
          load_tx   = 1'b1;
          addr_step = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // On the command edge the address comes straight from the byte being completed.
  assign rd_addr = (state == CMD) ? cmd_addr : addr;
  assign rd_oor  = (state == CMD) ? cmd_oor  : oor;
  assign rd_byte = rd_oor ? 8'hFF : regs[rd_addr];

  always_ff @(posedge spi_clock or negedge sysrst_n) begin
    if (!sysrst_n) begin
      rx_sr    <= 8'h00;
      tx_sr    <= 8'hFF;
      bit_cnt  <= 3'd0;
      addr     <= '0;
      oor      <= 1'b0;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (cs_n) begin
      tx_sr    <= 8'hFF;
      bit_cnt  <= 3'd0;
      rx_valid <= 1'b0;
    end else begin
      rx_sr    <= rx_next;
      bit_cnt  <= bit_cnt + 3'd1;
      tx_sr    <= load_tx ? rd_byte : {tx_sr[6:0], 1'b1};
      rx_valid <= byte_done;
      if (byte_done) rx_byte <= rx_next;
      if (cmd_done) begin
        addr <= rx_next[7] ? cmd_addr + AW'(1) : cmd_addr;
        oor  <= cmd_oor;
      end else if (addr_step) begin
        addr <= addr + AW'(1);
      end
    end
  end

  // Sticky error; a new abort on the same edge as err_clr keeps it set.
  always_ff @(posedge spi_clock or negedge sysrst_n) begin
    if (!sysrst_n) frame_err <= 1'b0;
    else           frame_err <= (cs_n && (bit_cnt != 3'd0)) || (frame_err && !err_clr);
  end

  // SPI write has priority over a local write to the same register.
  always_ff @(posedge spi_clock or negedge sysrst_n) begin
    if (!sysrst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (spi_we && (addr == AW'(i)))               regs[i] <= rx_next;
        else if (local_we && (local_addr == AW'(i))) regs[i] <= local_din;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) reg_q[8*i +: 8] = regs[i];
  end

  assign miso    = tx_sr[7];
  assign miso_oe = ~cs_n;
  assign active  = (state != IDLE);

endmodule

// File: tb/tb_spi_target_regfile.sv
// Bench for spi_target_regfile: hand vectors, corner sequences, and random frames against a frame-level model.
// rx_valid is a single-cycle strobe with no back-pressure; every pulse carries one byte in rx_byte.
module tb_spi_target_regfile;

  localparam int NREGS = 8;
  localparam int AW    = 3;

  logic                spi_clock;
  logic                sysrst_n;
  logic                cs_n;
  logic                mosi;
  logic                miso;
  logic                miso_oe;
  logic [8*NREGS-1:0]  reg_q;
  logic                local_we;
  logic [AW-1:0]       local_addr;
  logic [7:0]          local_din;
  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic                frame_err;
  logic                err_clr;
  logic                active;

  spi_target_regfile #(.NREGS(NREGS), .RESET_VAL(8'h00)) dut (
    .spi_clock  (spi_clock),
    .sysrst_n   (sysrst_n),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .reg_q      (reg_q),
    .local_we   (local_we),
    .local_addr (local_addr),
    .local_din  (local_din),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .err_clr    (err_clr),
    .active     (active)
  );

  // ---------------- clock / reset ----------------
  initial spi_clock = 1'b0;
  always #5 spi_clock = ~spi_clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model    [NREGS];
  logic [7:0] exp_q    [$];
  logic [7:0] obs_q    [$];
  logic [7:0] tx_buf   [$];
  logic [7:0] rx_buf   [$];
  logic [7:0] exp_miso [$];

  always @(negedge spi_clock) begin
    if (rx_valid) obs_q.push_back(rx_byte);
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    logic [8*NREGS-1:0] e;
    for (int i = 0; i < NREGS; i++) e[8*i +: 8] = model[i];
    checks++;
    if (reg_q !== e) begin
      errors++;
      $display("FAIL %s regfile: got %h expected %h", name, reg_q, e);
    end
  endtask

  task automatic drain(input string name);
    logic [7:0] o;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s rx_byte: got unexpected %02h expected none", name, o);
      end else begin
        checks--;
        check8({name, " rx_byte"}, o, exp_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s rx_valid count: got %0d missing expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // ---------------- reference model (frame level) ----------------
  task automatic model_frame();
    logic [7:0] cmd;
    int a;
    bit bad;
    exp_miso.delete();
    exp_miso.push_back(8'hFF);
    cmd = tx_buf[0];
    a   = int'(cmd[6:0]);
    bad = (a >= NREGS);
    for (int k = 1; k < tx_buf.size(); k++) begin
      if (cmd[7]) begin
        exp_miso.push_back(bad ? 8'hFF : model[a % NREGS]);
      end else begin
        if (!bad) model[a % NREGS] = tx_buf[k];
        exp_miso.push_back(8'hFF);
      end
      a++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic xfer_byte(input logic [7:0] tx, input logic lw, input logic [AW-1:0] la,
                           input logic [7:0] ld, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      @(negedge spi_clock);
      rx[i] = miso;
      cs_n  = 1'b0;
      mosi  = tx[i];
      if (lw && i == 0) begin
        local_we   = 1'b1;
        local_addr = la;
        local_din  = ld;
      end
    end
    if (lw) begin
      @(posedge spi_clock);
      #1 local_we = 1'b0;
    end
  endtask

  task automatic partial_bits(input logic [7:0] tx, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge spi_clock);
      cs_n = 1'b0;
      mosi = tx[i];
    end
  endtask

  task automatic end_frame();
    @(negedge spi_clock);
    cs_n = 1'b1;
    @(posedge spi_clock);
    #1;
  endtask

  task automatic run_frame();
    logic [7:0] b;
    rx_buf.delete();
    foreach (tx_buf[k]) begin
      xfer_byte(tx_buf[k], 1'b0, '0, 8'h00, b);
      rx_buf.push_back(b);
      exp_q.push_back(tx_buf[k]);
    end
    end_frame();
  endtask

  task automatic check_miso(input string name);
    for (int k = 0; k < rx_buf.size(); k++)
      check8($sformatf("%s miso[%0d]", name, k), rx_buf[k], exp_miso[k]);
  endtask

  task automatic local_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge spi_clock);
    local_we   = 1'b1;
    local_addr = a;
    local_din  = d;
    @(negedge spi_clock);
    local_we   = 1'b0;
    model[a]   = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [2:0]  n;
    logic [31:0] tx;
    logic [31:0] exp_miso;
    logic [3:0]  reg_idx;
    logic [7:0]  reg_val;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vec [NVEC];

  initial begin
    logic [7:0] b;
    string name;

    vec[0]  = '{3'd3, 32'h02A53C00, 32'hFFFFFF00, 4'd3, 8'h3C};
    vec[1]  = '{3'd2, 32'h07110000, 32'hFFFF0000, 4'd7, 8'h11};
    vec[2]  = '{3'd2, 32'h00220000, 32'hFFFF0000, 4'd0, 8'h22};
    vec[3]  = '{3'd3, 32'h87000000, 32'hFF112200, 4'd7, 8'h11};
    vec[4]  = '{3'd3, 32'h82000000, 32'hFFA53C00, 4'd2, 8'hA5};
    vec[5]  = '{3'd2, 32'h10FF0000, 32'hFFFF0000, 4'd0, 8'h22};
    vec[6]  = '{3'd2, 32'h90000000, 32'hFFFF0000, 4'd0, 8'h22};
    vec[7]  = '{3'd4, 32'h83000000, 32'hFF3C0000, 4'd4, 8'h00};
    vec[8]  = '{3'd4, 32'h06778899, 32'hFFFFFFFF, 4'd0, 8'h99};
    vec[9]  = '{3'd4, 32'h86000000, 32'hFF778899, 4'd6, 8'h77};
    vec[10] = '{3'd2, 32'h8F000000, 32'hFFFF0000, 4'd1, 8'h00};

    sysrst_n   = 1'b0;
    cs_n       = 1'b1;
    mosi       = 1'b0;
    local_we   = 1'b0;
    local_addr = '0;
    local_din  = 8'h00;
    err_clr    = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;

    repeat (3) @(negedge spi_clock);
    sysrst_n = 1'b1;
    @(posedge spi_clock);
    #1;
    check_regs("reset");
    check1("reset miso", miso, 1'b1);
    check1("reset miso_oe", miso_oe, 1'b0);
    check1("reset active", active, 1'b0);
    check1("reset frame_err", frame_err, 1'b0);
    check1("reset rx_valid", rx_valid, 1'b0);
    check8("reset rx_byte", rx_byte, 8'h00);

    // Reset asserted in the middle of a write frame
    xfer_byte(8'h01, 1'b0, '0, 8'h00, b);
    exp_q.push_back(8'h01);
    xfer_byte(8'hAB, 1'b0, '0, 8'h00, b);
    exp_q.push_back(8'hAB);
    partial_bits(8'hC3, 3);
    @(posedge spi_clock);
    #2 sysrst_n = 1'b0;
    #1;
    check_regs("midreset");
    check1("midreset miso", miso, 1'b1);
    check1("midreset active", active, 1'b0);
    check1("midreset frame_err", frame_err, 1'b0);
    @(negedge spi_clock);
    cs_n = 1'b1;
    @(negedge spi_clock);
    sysrst_n = 1'b1;
    @(posedge spi_clock);
    #1;
    drain("midreset");

    // Table-driven frames
    for (int v = 0; v < NVEC; v++) begin
      name = $sformatf("vec%0d", v);
      tx_buf.delete();
      for (int k = 0; k < int'(vec[v].n); k++) tx_buf.push_back(vec[v].tx[31-8*k -: 8]);
      model_frame();
      run_frame();
      drain(name);
      check_miso(name);
      for (int k = 0; k < int'(vec[v].n); k++)
        check8($sformatf("%s tbl miso[%0d]", name, k), rx_buf[k], vec[v].exp_miso[31-8*k -: 8]);
      check8({name, " reg"}, reg_q[8*int'(vec[v].reg_idx) +: 8], vec[v].reg_val);
      check_regs(name);
    end

    // Aborted data byte
    xfer_byte(8'h05, 1'b0, '0, 8'h00, b);
    exp_q.push_back(8'h05);
    partial_bits(8'hE7, 5);
    end_frame();
    check1("abort frame_err", frame_err, 1'b1);
    check1("abort active", active, 1'b0);
    check1("abort miso", miso, 1'b1);
    check_regs("abort");
    drain("abort");
    repeat (3) @(posedge spi_clock);
    #1;
    check1("abort sticky", frame_err, 1'b1);
    @(negedge spi_clock);
    err_clr = 1'b1;
    @(negedge spi_clock);
    err_clr = 1'b0;
    check1("err_clr", frame_err, 1'b0);
    tx_buf = '{8'h05, 8'h5A};
    model_frame();
    run_frame();
    drain("clean");
    check8("clean reg5", reg_q[47:40], 8'h5A);
    check_regs("clean");
    check1("clean frame_err", frame_err, 1'b0);

    // Abort coinciding with err_clr: the set wins
    xfer_byte(8'h06, 1'b0, '0, 8'h00, b);
    exp_q.push_back(8'h06);
    partial_bits(8'h00, 2);
    @(negedge spi_clock);
    cs_n    = 1'b1;
    err_clr = 1'b1;
    @(negedge spi_clock);
    err_clr = 1'b0;
    check1("setwins frame_err", frame_err, 1'b1);
    drain("setwins");
    check_regs("setwins");
    @(negedge spi_clock);
    err_clr = 1'b1;
    @(negedge spi_clock);
    err_clr = 1'b0;
    check1("setwins clr", frame_err, 1'b0);

    // SPI and local write on the same edge, same register then different registers
    xfer_byte(8'h01, 1'b0, '0, 8'h00, b);
    exp_q.push_back(8'h01);
    xfer_byte(8'h55, 1'b1, 3'd1, 8'hAA, b);
    exp_q.push_back(8'h55);
    end_frame();
    model[1] = 8'h55;
    check8("collide same reg1", reg_q[15:8], 8'h55);
    check_regs("collide same");
    drain("collide same");
    local_write(3'd1, 8'h00);
    xfer_byte(8'h01, 1'b0, '0, 8'h00, b);
    exp_q.push_back(8'h01);
    xfer_byte(8'h55, 1'b1, 3'd4, 8'hAA, b);
    exp_q.push_back(8'h55);
    end_frame();
    model[1] = 8'h55;
    model[4] = 8'hAA;
    check8("collide diff reg1", reg_q[15:8], 8'h55);
    check8("collide diff reg4", reg_q[39:32], 8'hAA);
    check_regs("collide diff");
    drain("collide diff");

    // Random frames with interleaved local writes
    for (int f = 0; f < 60; f++) begin
      logic [6:0] a;
      name = $sformatf("rand%0d", f);
      if ($urandom_range(0, 2) == 0) local_write(AW'($urandom_range(0, NREGS-1)), 8'($urandom));
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, NREGS-1));
      tx_buf.delete();
      tx_buf.push_back({1'($urandom_range(0, 1)), a});
      for (int k = $urandom_range(0, 5); k > 0; k--) tx_buf.push_back(8'($urandom));
      model_frame();
      run_frame();
      drain(name);
      check_miso(name);
      check_regs(name);
    end
    check1("final frame_err", frame_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_target_regfile.md
Name: spi_target_regfile

Overview:
- SPI target (responder) for the glue CPLD's SPI master shift engine: accepts master-driven SCLK/MOSI/CS_N and returns MISO.
- Exposes a small byte-wide register file, written and read over SPI with auto-incrementing addresses.
- Serves as on-board loopback/test target and as the template for SPI-attached control registers; local logic also gets a write port.
- Everything runs in the spi_clock (SCLK) domain.

Parameters:
NREGS, 8, number of 8-bit registers; power of 2, range 2..128
RESET_VAL, 8'h00, reset value of every register

Ports:
spi_clock  input  1  SPI serial clock from master; all state on rising edge
sysrst_n  input  1  asynchronous active-low reset
cs_n  input  1  target select, active low, sampled on spi_clock rising edge
mosi  input  1  serial data in, MSB first
miso  output  1  serial data out, MSB first (= tx_sr[7])
miso_oe  output  1  MISO drive enable (= ~cs_n); top level tristates when 0
reg_q  output  8*NREGS  flattened register file; reg i at [8i+7:8i]
local_we  input  1  local write strobe (spi_clock domain)
local_addr  input  clog2(NREGS)  local write address
local_din  input  8  local write data
rx_byte  output  8  last completed received byte (command or data)
rx_valid  output  1  one-cycle pulse when rx_byte updates
frame_err  output  1  sticky: CS_N deasserted mid-byte
err_clr  input  1  clears frame_err
active  output  1  1 while in a frame (state != IDLE)

Behaviour:
- Interface is decided: reset sysrst_n, asynchronous, active-low; clock spi_clock.
- Reset values: all registers RESET_VAL, tx_sr 8'hFF (miso=1), rx_sr 0, bit_cnt 0, addr 0, rx_byte 0, rx_valid 0, frame_err 0, state IDLE.
- Reset mid-frame aborts the frame; the master must deassert cs_n before its next transfer.
- Shift timing, each rising edge with cs_n=0:
  - rx_sr <= {rx_sr[6:0], mosi}; bit_cnt <= bit_cnt+1 (3-bit, wraps).
  - Byte completes on the edge where bit_cnt==7; completed byte = {rx_sr[6:0], mosi}.
  - tx_sr shifts left, LSB filled with 1, except on a byte-complete edge in a read frame, where tx_sr loads the next read byte.
  - The master samples miso on the falling edge, so each bit is stable for a full half-cycle.
- States: IDLE, CMD, WDATA, RDATA.
  - IDLE: on a rising edge with cs_n=0, shift the first bit and enter CMD.
  - CMD, byte complete: cmd[7]=1 means read, else write; cmd[6:0] is the start address.
    - If cmd[6:AW] != 0 (AW = clog2(NREGS)), the frame is out-of-range: writes are ignored and reads return 8'hFF.
    - Read: load tx_sr with reg[addr] (or 8'hFF if out-of-range), addr <= addr+1, go to RDATA.
    - Write: go to WDATA.
  - WDATA, byte complete: if in range, reg[addr] <= byte; addr <= addr+1.
  - RDATA, byte complete: received byte is discarded for storage; tx_sr <= reg[addr] (or 8'hFF), addr <= addr+1.
  - Address increments wrap modulo NREGS.
  - Any state, cs_n=1 on a rising edge: go to IDLE, bit_cnt <= 0, tx_sr <= 8'hFF. If bit_cnt != 0, set frame_err; the partial byte is discarded and no register is written.
- Read data is sampled at the byte-complete edge, so a write earlier in the same frame is visible.
- rx_byte/rx_valid: on every byte-complete edge (command and data bytes), rx_byte <= byte and rx_valid=1 for one cycle.
- Local write: on local_we, reg[local_addr] <= local_din. If it collides with an SPI write to the same register on the same edge, the SPI write wins; different registers both complete.
- frame_err: if err_clr and a set event coincide, set wins.
- SCLK runs only during transfers, so cs_n deassertion is recognised only on the next SCLK edge. The master issues at least one SCLK edge with cs_n=1 between frames.

Test Plan:
- Reset: sysrst_n low mid-transfer -> reg_q all 8'h00, miso=1, active=0, frame_err=0.
- Write burst: cs_n=0, shift 8'h02, 8'hA5, 8'h3C, then cs_n=1 -> reg2=8'hA5, reg3=8'h3C; three rx_valid pulses with rx_byte 02, A5, 3C.
- Read burst with wrap: preload reg7=8'h11, reg0=8'h22; shift 8'h87 plus two dummy bytes -> master captures 8'h11 then 8'h22.
- Out-of-range: write cmd 8'h10 then 8'hFF -> no reg_q change. Read cmd 8'h90 -> MISO returns 8'hFF.
- Aborted byte: cs_n high after 5 bits of a data byte -> register unchanged, frame_err=1. err_clr pulse -> frame_err=0; a following clean frame works.
- Collision: SPI writes reg1=8'h55 on the same edge as local_we to reg1 with 8'hAA -> reg1=8'h55. Repeat with local_addr=4 -> reg1=8'h55 and reg4=8'hAA.
